// File: rtl/glb_dram_xfer_engine.sv
// DRAM <-> GLB burst transfer engine: LOAD streams DRAM beats into a GLB channel and
// STORE streams GLB reads out to DRAM, both through one shared circular FIFO.
module glb_dram_xfer_engine #(
    parameter  int DATA_WIDTH = 64,
    parameter  int DEPTH      = 16,
    parameter  int NUM_CH     = 4,
    parameter  int ADDR_WIDTH = 20,
    parameter  int LEN_WIDTH  = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PW         = $clog2(DEPTH) + 1
) (
    input  logic                  core_clk,
    input  logic                  core_reset,
    input  logic                  start,
    input  logic                  dir,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    input  logic                  dram_in_valid,
    output logic                  dram_in_ready,
    input  logic [DATA_WIDTH-1:0] dram_in_data,
    output logic                  dram_out_valid,
    input  logic                  dram_out_ready,
    output logic [DATA_WIDTH-1:0] dram_out_data,
    output logic [NUM_CH-1:0]     glb_w_en,
    output logic [ADDR_WIDTH-1:0] glb_waddr,
    output logic [DATA_WIDTH-1:0] glb_wdata,
    output logic                  glb_r_en,
    output logic [ADDR_WIDTH-1:0] glb_raddr,
    input  logic [DATA_WIDTH-1:0] glb_rdata,
    output logic [PW-1:0]         fifo_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_t;

    state_t                state;
    logic [CH_W-1:0]       ch_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  in_cnt;
    logic [LEN_WIDTH-1:0]  out_cnt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         count;
    logic [PW:0]           occupancy;
    logic                  full;
    logic                  empty;
    logic                  rd_pending;

    logic                  load_st;
    logic                  store_st;
    logic                  in_left;
    logic                  credit_ok;
    logic                  wr_fire;
    logic                  dram_in_fire;
    logic                  push;
    logic                  push_ok;
    logic                  pop;
    logic                  last_pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] head;

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign head      = mem[rd_ptr[PW-2:0]];
    assign fifo_count = count;

    assign load_st   = (state == S_LOAD);
    assign store_st  = (state == S_STORE);
    assign in_left   = (in_cnt < len_q);

    // A read in flight already owns a FIFO slot, so it counts against the space left.
    assign occupancy = {1'b0, count} + {{PW{1'b0}}, rd_pending};
    assign credit_ok = (occupancy < (PW+1)'(DEPTH));

    assign dram_in_ready  = load_st && !full && in_left;
    assign dram_in_fire   = dram_in_valid && dram_in_ready;
    assign wr_fire        = load_st && !empty;
    assign glb_r_en       = store_st && in_left && credit_ok;
    assign dram_out_valid = store_st && !empty;

    assign push      = dram_in_fire || (store_st && rd_pending);
    assign push_data = store_st ? glb_rdata : dram_in_data;
    assign pop       = wr_fire || (dram_out_valid && dram_out_ready);
    assign push_ok   = push && (!full || pop);
    assign last_pop  = pop && ((out_cnt + LEN_WIDTH'(1)) == len_q);

    assign glb_w_en      = wr_fire ? (NUM_CH'(1) << ch_q) : '0;
    assign glb_wdata     = wr_fire ? head : '0;
    assign glb_waddr     = load_st ? addr_q : '0;
    assign glb_raddr     = store_st ? addr_q : '0;
    assign dram_out_data = dram_out_valid ? head : '0;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge core_clk) begin
        if (push_ok && !core_reset) begin
            mem[wr_ptr[PW-2:0]] <= push_data;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            state      <= S_IDLE;
            ch_q       <= '0;
            stride_q   <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= glb_r_en;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);

            // addr_q serves as the write address in LOAD and the read address in STORE.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ch_q     <= ch_sel;
                        stride_q <= stride;
                        addr_q   <= base_address;
                        len_q    <= length;
                        in_cnt   <= '0;
                        out_cnt  <= '0;
                        if (length == '0) state <= S_DONE;
                        else if (dir)     state <= S_STORE;
                        else              state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (dram_in_fire) in_cnt <= in_cnt + LEN_WIDTH'(1);
                    if (pop) begin
                        out_cnt <= out_cnt + LEN_WIDTH'(1);
                        addr_q  <= addr_q + stride_q;
                    end
                    if (last_pop) state <= S_DONE;
                end
                S_STORE: begin
                    if (glb_r_en) begin
                        in_cnt <= in_cnt + LEN_WIDTH'(1);
                        addr_q <= addr_q + stride_q;
                    end
                    if (pop) out_cnt <= out_cnt + LEN_WIDTH'(1);
                    if (last_pop) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glb_dram_xfer_engine.sv
// Directed testbench for glb_dram_xfer_engine; inputs change on the falling edge and
// outputs are sampled 1 ns later, so every handshake seen completes on the next rising edge.
module tb_glb_dram_xfer_engine;

    localparam int DW = 64;
    localparam int DEPTH = 16;
    localparam int NUM_CH = 4;
    localparam int AW = 20;
    localparam int LW = 16;

    logic          core_clk = 1'b0;
    logic          core_reset;
    logic          start;
    logic          dir;
    logic [1:0]    ch_sel;
    logic [AW-1:0] base_address;
    logic [AW-1:0] stride;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic          dram_in_valid;
    logic          dram_in_ready;
    logic [DW-1:0] dram_in_data;
    logic          dram_out_valid;
    logic          dram_out_ready;
    logic [DW-1:0] dram_out_data;
    logic [NUM_CH-1:0] glb_w_en;
    logic [AW-1:0] glb_waddr;
    logic [DW-1:0] glb_wdata;
    logic          glb_r_en;
    logic [AW-1:0] glb_raddr;
    logic [DW-1:0] glb_rdata;
    logic [4:0]    fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 core_clk = ~core_clk;

    glb_dram_xfer_engine #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .core_clk(core_clk), .core_reset(core_reset), .start(start), .dir(dir),
        .ch_sel(ch_sel), .base_address(base_address), .stride(stride), .length(length),
        .busy(busy), .done(done),
        .dram_in_valid(dram_in_valid), .dram_in_ready(dram_in_ready), .dram_in_data(dram_in_data),
        .dram_out_valid(dram_out_valid), .dram_out_ready(dram_out_ready), .dram_out_data(dram_out_data),
        .glb_w_en(glb_w_en), .glb_waddr(glb_waddr), .glb_wdata(glb_wdata),
        .glb_r_en(glb_r_en), .glb_raddr(glb_raddr), .glb_rdata(glb_rdata),
        .fifo_count(fifo_count)
    );

    function automatic logic [DW-1:0] load_word(input int k);
        return {32'hD0D0_0000, 32'(k)};
    endfunction

    function automatic logic [DW-1:0] glb_word(input logic [AW-1:0] a);
        return {32'hCAFE_0000, 12'h000, a};
    endfunction

    task automatic do_start(input logic d, input logic [1:0] ch, input logic [AW-1:0] b,
                            input logic [AW-1:0] s, input logic [LW-1:0] l);
        @(negedge core_clk);
        start = 1'b1; dir = d; ch_sel = ch; base_address = b; stride = s; length = l;
        @(negedge core_clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        core_reset = 1'b1;
        start = 1'b0; dir = 1'b0; ch_sel = '0; base_address = '0; stride = '0; length = '0;
        dram_in_valid = 1'b0; dram_in_data = '0; dram_out_ready = 1'b0; glb_rdata = '0;
        repeat (3) @(negedge core_clk);
        core_reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", done); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (glb_w_en !== 4'b0000) begin errors++; $display("FAIL reset_w_en got=%b exp=0000", glb_w_en); end
        checks++; if (dram_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0h exp=0", dram_in_ready); end
        checks++; if (dram_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", dram_out_valid); end
        checks++; if (glb_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en got=%0h exp=0", glb_r_en); end
        @(negedge core_clk);
    endtask

    task automatic test_load_basic();
        logic [AW-1:0] exp_addr [5];
        int acc = 0, wr = 0, dones = 0, t_acc = -1, t_wr = -1;
        exp_addr = '{20'h00100, 20'h00104, 20'h00108, 20'h0010C, 20'h00110};
        do_start(1'b0, 2'd2, 20'h00100, 20'h4, 16'd5);
        for (int cyc = 0; cyc < 40; cyc++) begin
            dram_in_valid = 1'b1; dram_in_data = load_word(acc);
            #1;
            if (dram_in_ready) begin if (acc == 0) t_acc = cyc; acc++; end
            if (glb_w_en !== 4'b0000) begin
                if (wr == 0) t_wr = cyc;
                if (wr < 5) begin
                    checks++; if (glb_w_en !== 4'b0100) begin errors++; $display("FAIL load_w_en beat %0d got=%b exp=0100", wr, glb_w_en); end
                    checks++; if (glb_waddr !== exp_addr[wr]) begin errors++; $display("FAIL load_addr beat %0d got=%h exp=%h", wr, glb_waddr, exp_addr[wr]); end
                    checks++; if (glb_wdata !== load_word(wr)) begin errors++; $display("FAIL load_data beat %0d got=%h exp=%h", wr, glb_wdata, load_word(wr)); end
                end
                wr++;
            end
            if (done) dones++;
            @(negedge core_clk);
        end
        dram_in_valid = 1'b0;
        #1;
        checks++; if (wr != 5) begin errors++; $display("FAIL load_writes got=%0d exp=5", wr); end
        checks++; if (acc != 5) begin errors++; $display("FAIL load_accepted got=%0d exp=5", acc); end
        checks++; if (dones != 1) begin errors++; $display("FAIL load_done_pulses got=%0d exp=1", dones); end
        checks++; if (t_wr != t_acc + 1) begin errors++; $display("FAIL load_latency got=%0d exp=%0d", t_wr, t_acc + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy_end got=%0h exp=0", busy); end
    endtask

    task automatic test_load_drain();
        int acc = 0, wr = 0, dones = 0;
        logic exp_rdy;
        do_start(1'b0, 2'd0, 20'h00000, 20'h1, 16'd20);
        for (int cyc = 0; cyc < 60; cyc++) begin
            dram_in_valid = ((cyc % 20) < 16); dram_in_data = load_word(acc);
            #1;
            if (busy && !done) begin
                checks++; if (fifo_count > 5'd16) begin errors++; $display("FAIL drain_count cyc %0d got=%0d exp<=16", cyc, fifo_count); end
                exp_rdy = (acc < 20) && (fifo_count != 5'd16);
                checks++; if (dram_in_ready !== exp_rdy) begin errors++; $display("FAIL drain_ready cyc %0d got=%0h exp=%0h", cyc, dram_in_ready, exp_rdy); end
            end
            if (dram_in_valid && dram_in_ready) acc++;
            if (glb_w_en !== 4'b0000) begin
                checks++; if (glb_w_en !== 4'b0001 || glb_waddr !== AW'(wr) || glb_wdata !== load_word(wr)) begin
                    errors++; $display("FAIL drain_write beat %0d got en=%b addr=%h data=%h exp en=0001 addr=%h data=%h",
                                       wr, glb_w_en, glb_waddr, glb_wdata, AW'(wr), load_word(wr));
                end
                wr++;
            end
            if (done) dones++;
            @(negedge core_clk);
        end
        dram_in_valid = 1'b0;
        checks++; if (wr != 20) begin errors++; $display("FAIL drain_writes got=%0d exp=20", wr); end
        checks++; if (acc != 20) begin errors++; $display("FAIL drain_accepted got=%0d exp=20", acc); end
        checks++; if (dones != 1) begin errors++; $display("FAIL drain_done_pulses got=%0d exp=1", dones); end
    endtask

    task automatic test_store_wrap();
        logic [AW-1:0] exp_addr [4];
        logic [AW-1:0] pend_addr = '0;
        logic [DW-1:0] held_data = '0;
        logic pend = 1'b0, held = 1'b0;
        int rd = 0, outn = 0, dones = 0;
        exp_addr = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
        do_start(1'b1, 2'd0, 20'hFFFFE, 20'h1, 16'd4);
        for (int cyc = 0; cyc < 40; cyc++) begin
            glb_rdata = pend ? glb_word(pend_addr) : '0;
            dram_out_ready = ((cyc % 2) == 0);
            #1;
            if (held) begin
                checks++; if (dram_out_valid !== 1'b1 || dram_out_data !== held_data) begin
                    errors++; $display("FAIL wrap_hold cyc %0d got v=%0h d=%h exp v=1 d=%h", cyc, dram_out_valid, dram_out_data, held_data);
                end
            end
            held = dram_out_valid && !dram_out_ready;
            held_data = dram_out_data;
            if (dram_out_valid && dram_out_ready) begin
                if (outn < 4) begin
                    checks++; if (dram_out_data !== glb_word(exp_addr[outn])) begin
                        errors++; $display("FAIL wrap_data beat %0d got=%h exp=%h", outn, dram_out_data, glb_word(exp_addr[outn]));
                    end
                end
                outn++;
            end
            pend = glb_r_en; pend_addr = glb_raddr;
            if (glb_r_en) begin
                if (rd < 4) begin
                    checks++; if (glb_raddr !== exp_addr[rd]) begin errors++; $display("FAIL wrap_raddr read %0d got=%h exp=%h", rd, glb_raddr, exp_addr[rd]); end
                end
                rd++;
            end
            if (done) dones++;
            @(negedge core_clk);
        end
        glb_rdata = '0; dram_out_ready = 1'b0;
        #1;
        checks++; if (rd != 4) begin errors++; $display("FAIL wrap_reads got=%0d exp=4", rd); end
        checks++; if (outn != 4) begin errors++; $display("FAIL wrap_beats got=%0d exp=4", outn); end
        checks++; if (dones != 1) begin errors++; $display("FAIL wrap_done_pulses got=%0d exp=1", dones); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_end got=%0h exp=0", busy); end
    endtask

    task automatic test_store_stall();
        logic [AW-1:0] pend_addr = '0;
        logic [AW-1:0] exp_a;
        logic pend = 1'b0;
        int rd = 0, outn = 0, dones = 0;
        do_start(1'b1, 2'd0, 20'h00200, 20'h2, 16'd40);
        for (int cyc = 0; cyc < 120; cyc++) begin
            glb_rdata = pend ? glb_word(pend_addr) : '0;
            dram_out_ready = (cyc >= 30);
            #1;
            pend = glb_r_en; pend_addr = glb_raddr;
            if (glb_r_en) begin
                exp_a = AW'(32'h200 + 2 * rd);
                checks++; if (glb_raddr !== exp_a) begin errors++; $display("FAIL stall_raddr read %0d got=%h exp=%h", rd, glb_raddr, exp_a); end
                rd++;
            end
            if (cyc < 30) begin
                checks++; if (fifo_count > 5'd16) begin errors++; $display("FAIL stall_overflow cyc %0d got=%0d exp<=16", cyc, fifo_count); end
            end
            if (cyc == 29) begin
                checks++; if (rd != 16) begin errors++; $display("FAIL stall_reads got=%0d exp=16", rd); end
                checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL stall_count got=%0d exp=16", fifo_count); end
            end
            if (dram_out_valid && dram_out_ready) begin
                exp_a = AW'(32'h200 + 2 * outn);
                checks++; if (dram_out_data !== glb_word(exp_a)) begin errors++; $display("FAIL stall_data beat %0d got=%h exp=%h", outn, dram_out_data, glb_word(exp_a)); end
                outn++;
            end
            if (done) dones++;
            @(negedge core_clk);
        end
        glb_rdata = '0; dram_out_ready = 1'b0;
        checks++; if (rd != 40) begin errors++; $display("FAIL stall_total_reads got=%0d exp=40", rd); end
        checks++; if (outn != 40) begin errors++; $display("FAIL stall_beats got=%0d exp=40", outn); end
        checks++; if (dones != 1) begin errors++; $display("FAIL stall_done_pulses got=%0d exp=1", dones); end
    endtask

    task automatic test_zero_and_ignore();
        logic [AW-1:0] exp_addr [3];
        int acc = 0, wr = 0, dones = 0, rens = 0;
        exp_addr = '{20'h00040, 20'h00048, 20'h00050};
        do_start(1'b0, 2'd1, 20'h00055, 20'h1, 16'd0);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%0h exp=1", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy got=%0h exp=1", busy); end
        checks++; if (glb_w_en !== 4'b0000 || glb_r_en !== 1'b0 || dram_in_ready !== 1'b0) begin
            errors++; $display("FAIL zero_enables got w_en=%b r_en=%0h rdy=%0h exp all 0", glb_w_en, glb_r_en, dram_in_ready);
        end
        @(negedge core_clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_idle got done=%0h busy=%0h exp 0 0", done, busy); end

        do_start(1'b0, 2'd1, 20'h00040, 20'h8, 16'd3);
        for (int cyc = 0; cyc < 30; cyc++) begin
            dram_in_valid = 1'b1; dram_in_data = load_word(acc);
            if (cyc == 1) begin start = 1'b1; dir = 1'b1; ch_sel = 2'd3; base_address = 20'hAAAAA; length = 16'd10; end
            if (cyc == 2) start = 1'b0;
            #1;
            if (dram_in_ready) acc++;
            if (glb_r_en) rens++;
            if (glb_w_en !== 4'b0000) begin
                if (wr < 3) begin
                    checks++; if (glb_w_en !== 4'b0010 || glb_waddr !== exp_addr[wr] || glb_wdata !== load_word(wr)) begin
                        errors++; $display("FAIL ignore_write beat %0d got en=%b addr=%h data=%h exp en=0010 addr=%h data=%h",
                                           wr, glb_w_en, glb_waddr, glb_wdata, exp_addr[wr], load_word(wr));
                    end
                end
                wr++;
            end
            if (done) dones++;
            @(negedge core_clk);
        end
        dram_in_valid = 1'b0;
        #1;
        checks++; if (wr != 3) begin errors++; $display("FAIL ignore_writes got=%0d exp=3", wr); end
        checks++; if (rens != 0) begin errors++; $display("FAIL ignore_reads got=%0d exp=0", rens); end
        checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_pulses got=%0d exp=1", dones); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end got=%0h exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] exp_addr [2];
        int acc = 0, wr = 0, dones = 0;
        exp_addr = '{20'h00010, 20'h00020};
        do_start(1'b0, 2'd0, 20'h00300, 20'h1, 16'd8);
        for (int cyc = 0; cyc < 30; cyc++) begin
            dram_in_valid = 1'b1; dram_in_data = load_word(acc);
            #1;
            if (dram_in_ready) acc++;
            if (glb_w_en !== 4'b0000) wr++;
            if (wr == 3) break;
            @(negedge core_clk);
        end
        checks++; if (wr != 3) begin errors++; $display("FAIL rstmid_reach got=%0d exp=3", wr); end
        core_reset = 1'b1; dram_in_valid = 1'b0;
        @(negedge core_clk);
        core_reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_state got busy=%0h done=%0h exp 0 0", busy, done); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count); end
        checks++; if (glb_w_en !== 4'b0000 || glb_waddr !== '0 || glb_wdata !== '0) begin
            errors++; $display("FAIL rstmid_glb_w got en=%b addr=%h data=%h exp 0", glb_w_en, glb_waddr, glb_wdata);
        end
        checks++; if (dram_in_ready !== 1'b0 || dram_out_valid !== 1'b0 || dram_out_data !== '0 || glb_r_en !== 1'b0 || glb_raddr !== '0) begin
            errors++; $display("FAIL rstmid_other got rdy=%0h ov=%0h od=%h ren=%0h ra=%h exp 0",
                               dram_in_ready, dram_out_valid, dram_out_data, glb_r_en, glb_raddr);
        end

        acc = 0; wr = 0;
        do_start(1'b0, 2'd3, 20'h00010, 20'h10, 16'd2);
        for (int cyc = 0; cyc < 20; cyc++) begin
            dram_in_valid = 1'b1; dram_in_data = load_word(acc);
            #1;
            if (dram_in_ready) acc++;
            if (glb_w_en !== 4'b0000) begin
                if (wr < 2) begin
                    checks++; if (glb_w_en !== 4'b1000 || glb_waddr !== exp_addr[wr] || glb_wdata !== load_word(wr)) begin
                        errors++; $display("FAIL rstmid_write beat %0d got en=%b addr=%h data=%h exp en=1000 addr=%h data=%h",
                                           wr, glb_w_en, glb_waddr, glb_wdata, exp_addr[wr], load_word(wr));
                    end
                end
                wr++;
            end
            if (done) dones++;
            @(negedge core_clk);
        end
        dram_in_valid = 1'b0;
        #1;
        checks++; if (wr != 2) begin errors++; $display("FAIL rstmid_writes got=%0d exp=2", wr); end
        checks++; if (dones != 1) begin errors++; $display("FAIL rstmid_done_pulses got=%0d exp=1", dones); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_end got=%0h exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_drain();
        test_store_wrap();
        test_store_stall();
        test_zero_and_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
